// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: 1149.1-style TAP, IR_LEN-bit IR, BSR/BYPASS/IDCODE/USER DRs.
// Capture/shift on TCK rise; update, TDO and TDO_en on TCK fall.
module jtag_tap_multi_dr #(
  parameter int unsigned IR_LEN     = 4,
  parameter int unsigned BSR_LEN    = 51,
  parameter int unsigned USER_LEN   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_en,
  input  logic [BSR_LEN-1:0]  bsr_capture,
  output logic [BSR_LEN-1:0]  bsr_update,
  output logic                Mode,
  input  logic [USER_LEN-1:0] user_capture,
  output logic [USER_LEN-1:0] user_update,
  output logic                user_strobe,
  output logic [IR_LEN-1:0]   instruction,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_e;

  typedef enum logic [1:0] {DR_BSR, DR_ID, DR_USER, DR_BYP} dr_e;

  localparam logic [IR_LEN-1:0] OP_EXTEST = IR_LEN'(0);
  localparam logic [IR_LEN-1:0] OP_SAMPLE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] OP_USER   = IR_LEN'(3);

  tap_e                state_q;
  logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
  logic [BSR_LEN-1:0]  bsr_sr_q, bsr_sr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [USER_LEN-1:0] user_sr_q, user_sr_d;
  logic                byp_q, byp_d;
  logic [IR_LEN-1:0]   ir_q;
  logic [BSR_LEN-1:0]  bsr_upd_q;
  logic [USER_LEN-1:0] user_upd_q;
  logic                strobe_q, tdo_q, tdo_en_q;
  dr_e                 sel;
  logic                dr_bit0;

  // Select the data register; unknown opcodes fall back to bypass
  always_comb begin
    sel = DR_BYP;
    unique case (1'b1)
      (ir_q == OP_EXTEST),
      (ir_q == OP_SAMPLE): sel = DR_BSR;
      (ir_q == OP_IDCODE): sel = DR_ID;
      (ir_q == OP_USER):   sel = DR_USER;
      default:             sel = DR_BYP;
    endcase
  end

  // Serial output bit of the selected DR
  always_comb begin
    dr_bit0 = byp_q;
    unique case (sel)
      DR_BSR:  dr_bit0 = bsr_sr_q[0];
      DR_ID:   dr_bit0 = id_sr_q[0];
      DR_USER: dr_bit0 = user_sr_q[0];
      DR_BYP:  dr_bit0 = byp_q;
    endcase
  end

  // TAP controller, standard TMS transitions
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      state_q <= TLR;
    end else begin
      unique case (state_q)
        TLR:    state_q <= TMS ? TLR    : RTI;
        RTI:    state_q <= TMS ? SEL_DR : RTI;
        SEL_DR: state_q <= TMS ? SEL_IR : CAP_DR;
        CAP_DR: state_q <= TMS ? EX1_DR : SH_DR;
        SH_DR:  state_q <= TMS ? EX1_DR : SH_DR;
        EX1_DR: state_q <= TMS ? UPD_DR : PAU_DR;
        PAU_DR: state_q <= TMS ? EX2_DR : PAU_DR;
        EX2_DR: state_q <= TMS ? UPD_DR : SH_DR;
        UPD_DR: state_q <= TMS ? SEL_DR : RTI;
        SEL_IR: state_q <= TMS ? TLR    : CAP_IR;
        CAP_IR: state_q <= TMS ? EX1_IR : SH_IR;
        SH_IR:  state_q <= TMS ? EX1_IR : SH_IR;
        EX1_IR: state_q <= TMS ? UPD_IR : PAU_IR;
        PAU_IR: state_q <= TMS ? EX2_IR : PAU_IR;
        EX2_IR: state_q <= TMS ? UPD_IR : SH_IR;
        UPD_IR: state_q <= TMS ? SEL_DR : RTI;
      endcase
    end
  end

  // Capture and shift next-state; unselected registers hold
  always_comb begin
    ir_sr_d   = ir_sr_q;
    bsr_sr_d  = bsr_sr_q;
    id_sr_d   = id_sr_q;
    user_sr_d = user_sr_q;
    byp_d     = byp_q;
    unique case (state_q)
      CAP_IR: ir_sr_d = IR_LEN'(1);
      SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_LEN-1:1]};
      CAP_DR: begin
        unique case (sel)
          DR_BSR:  bsr_sr_d  = bsr_capture;
          DR_ID:   id_sr_d   = IDCODE_VAL;
          DR_USER: user_sr_d = user_capture;
          DR_BYP:  byp_d     = 1'b0;
        endcase
      end
      SH_DR: begin
        unique case (sel)
          DR_BSR:  bsr_sr_d  = {TDI, bsr_sr_q[BSR_LEN-1:1]};
          DR_ID:   id_sr_d   = {TDI, id_sr_q[31:1]};
          DR_USER: user_sr_d = {TDI, user_sr_q[USER_LEN-1:1]};
          DR_BYP:  byp_d     = TDI;
        endcase
      end
      default: ;
    endcase
  end

  // Shift register state on the rising edge
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_sr_q   <= '0;
      bsr_sr_q  <= '0;
      id_sr_q   <= '0;
      user_sr_q <= '0;
      byp_q     <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      bsr_sr_q  <= bsr_sr_d;
      id_sr_q   <= id_sr_d;
      user_sr_q <= user_sr_d;
      byp_q     <= byp_d;
    end
  end

  // Falling-edge updates, TDO drive and user strobe
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_q       <= OP_IDCODE;
      bsr_upd_q  <= '0;
      user_upd_q <= '0;
      strobe_q   <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      tdo_en_q <= (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR) tdo_q <= ir_sr_q[0];
      if (state_q == SH_DR) tdo_q <= dr_bit0;
      if (state_q == TLR) ir_q <= OP_IDCODE;
      if (state_q == UPD_IR) ir_q <= ir_sr_q;
      if (state_q == UPD_DR) begin
        if (sel == DR_BSR) bsr_upd_q <= bsr_sr_q;
        if (sel == DR_USER) begin
          user_upd_q <= user_sr_q;
          strobe_q   <= 1'b1;
        end
      end
    end
  end

  assign TDO         = tdo_q;
  assign TDO_en      = tdo_en_q;
  assign bsr_update  = bsr_upd_q;
  assign user_update = user_upd_q;
  assign user_strobe = strobe_q;
  assign instruction = ir_q;
  assign Mode        = (ir_q == OP_EXTEST);
  assign tap_state   = state_q;

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr: randomized scan sequences vs a stream-level model.
// Expected TDO = captured DR bits followed by shifted-in TDI bits.
module tb_jtag_tap_multi_dr;

  localparam int IR_LEN = 4;
  localparam int BSR_LEN = 51;
  localparam int USER_LEN = 8;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic TCK = 1'b0;
  logic Reset = 1'b1;
  logic TMS, TDI;
  logic TDO, TDO_en, Mode, user_strobe;
  logic [BSR_LEN-1:0] bsr_cap, bsr_update;
  logic [USER_LEN-1:0] user_cap, user_update;
  logic [IR_LEN-1:0] instruction;
  logic [3:0] tap_state;

  int vec = 0;
  int err = 0;
  int mstate = 0;
  logic [BSR_LEN-1:0] m_bsr_upd;

  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  jtag_tap_multi_dr dut (
    .TCK(TCK), .Reset(Reset), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_en(TDO_en),
    .bsr_capture(bsr_cap), .bsr_update(bsr_update), .Mode(Mode),
    .user_capture(user_cap), .user_update(user_update),
    .user_strobe(user_strobe), .instruction(instruction),
    .tap_state(tap_state)
  );

  always #5 TCK = ~TCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int dr_len(input logic [IR_LEN-1:0] op);
    case (op)
      4'd0, 4'd1: return BSR_LEN;
      4'd2:       return 32;
      4'd3:       return USER_LEN;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] dr_cap(input logic [IR_LEN-1:0] op);
    case (op)
      4'd0, 4'd1: return 64'(bsr_cap);
      4'd2:       return 64'(IDV);
      4'd3:       return 64'(user_cap);
      default:    return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] exp_out(input logic [63:0] cap,
      input int len, input logic [63:0] din, input int n);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < n; k++) begin
      if (k < len) e[k] = cap[k];
      else e[k] = din[k-len];
    end
    return e;
  endfunction

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
    mstate = tms ? nxt1[mstate] : nxt0[mstate];
  endtask

  task automatic shift_dr(input int n, input logic [63:0] din,
      output logic [63:0] dout, output logic en_ok);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    dout[0] = TDO;
    en_ok = TDO_en;
    for (int k = 0; k < n; k++) begin
      tick(k == n - 1, din[k]);
      if (k < n - 1) begin
        dout[k+1] = TDO;
        en_ok = en_ok & TDO_en;
      end else begin
        en_ok = en_ok & ~TDO_en;
      end
    end
  endtask

  task automatic load_ir(input logic [IR_LEN-1:0] v,
      output logic [IR_LEN-1:0] cap);
    cap = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    cap[0] = TDO;
    for (int k = 0; k < IR_LEN; k++) begin
      tick(k == IR_LEN - 1, v[k]);
      if (k < IR_LEN - 1) cap[k+1] = TDO;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    TMS = 1'b1;
    TDI = 1'b0;
    @(negedge TCK);
    #1;
    vec += 8;
    if (tap_state !== 4'd0) begin err++; $display("FAIL rst_state got %0d want 0", tap_state); end
    if (instruction !== 4'd2) begin err++; $display("FAIL rst_instr got %0h want 2", instruction); end
    if (TDO !== 1'b0) begin err++; $display("FAIL rst_tdo got %b want 0", TDO); end
    if (TDO_en !== 1'b0) begin err++; $display("FAIL rst_tdo_en got %b want 0", TDO_en); end
    if (Mode !== 1'b0) begin err++; $display("FAIL rst_mode got %b want 0", Mode); end
    if (bsr_update !== '0) begin err++; $display("FAIL rst_bsr_upd got %h want 0", bsr_update); end
    if (user_update !== '0) begin err++; $display("FAIL rst_user_upd got %h want 0", user_update); end
    if (user_strobe !== 1'b0) begin err++; $display("FAIL rst_strobe got %b want 0", user_strobe); end
    Reset = 1'b0;
    mstate = 0;
  endtask

  task automatic test_idcode;
    logic [63:0] dout, e;
    logic en;
    tick(1'b0, 1'b0);
    vec++;
    if (tap_state !== 4'd1) begin err++; $display("FAIL id_rti got %0d want 1", tap_state); end
    shift_dr(32, 64'd0, dout, en);
    e = exp_out(dr_cap(4'd2), dr_len(4'd2), 64'd0, 32);
    vec += 2;
    if (dout !== e) begin err++; $display("FAIL idcode got %h want %h", dout, e); end
    if (en !== 1'b1) begin err++; $display("FAIL id_tdo_en got %b want 1", en); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bypass;
    logic [IR_LEN-1:0] cap;
    logic [63:0] din, dout, e;
    logic en;
    load_ir(4'hF, cap);
    vec += 3;
    if (cap !== 4'b0001) begin err++; $display("FAIL byp_ircap got %b want 0001", cap); end
    if (instruction !== 4'hF) begin err++; $display("FAIL byp_instr got %h want f", instruction); end
    if (Mode !== 1'b0) begin err++; $display("FAIL byp_mode got %b want 0", Mode); end
    din = 64'b1101;
    shift_dr(4, din, dout, en);
    e = exp_out(dr_cap(4'hF), dr_len(4'hF), din, 4);
    vec++;
    if (dout !== e) begin err++; $display("FAIL byp_1011 got %h want %h", dout, e); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      din = {32'd0, $urandom()};
      shift_dr(24, din, dout, en);
      e = exp_out(dr_cap(4'hF), dr_len(4'hF), din, 24);
      vec += 2;
      if (dout !== e) begin err++; $display("FAIL byp_rand got %h want %h", dout, e); end
      if (en !== 1'b1) begin err++; $display("FAIL byp_en got %b want 1", en); end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_unknown;
    logic [IR_LEN-1:0] cap;
    logic [63:0] din, dout, e;
    logic en;
    load_ir(4'h7, cap);
    vec += 2;
    if (cap !== 4'b0001) begin err++; $display("FAIL unk_ircap got %b want 0001", cap); end
    if (instruction !== 4'h7) begin err++; $display("FAIL unk_instr got %h want 7", instruction); end
    din = {48'd0, 16'($urandom())};
    shift_dr(16, din, dout, en);
    e = exp_out(dr_cap(4'h7), dr_len(4'h7), din, 16);
    vec++;
    if (dout !== e) begin err++; $display("FAIL unk_shift got %h want %h", dout, e); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_extest;
    logic [IR_LEN-1:0] cap;
    logic [63:0] din, dout, e, r;
    logic en;
    bsr_cap = '1;
    load_ir(4'h0, cap);
    vec++;
    if (Mode !== 1'b1) begin err++; $display("FAIL ext_mode got %b want 1", Mode); end
    din = '0;
    for (int i = 0; i < BSR_LEN; i++) din[i] = i[0];
    shift_dr(BSR_LEN, din, dout, en);
    e = exp_out(dr_cap(4'h0), dr_len(4'h0), din, BSR_LEN);
    vec += 2;
    if (dout !== e) begin err++; $display("FAIL ext_shift got %h want %h", dout, e); end
    if (en !== 1'b1) begin err++; $display("FAIL ext_en got %b want 1", en); end
    tick(1'b1, 1'b0);
    vec++;
    if (bsr_update !== din[BSR_LEN-1:0]) begin
      err++; $display("FAIL ext_upd got %h want %h", bsr_update, din[BSR_LEN-1:0]);
    end
    tick(1'b0, 1'b0);
    load_ir(4'h1, cap);
    vec++;
    if (Mode !== 1'b0) begin err++; $display("FAIL smp_mode got %b want 0", Mode); end
    r = {$urandom(), $urandom()};
    bsr_cap = r[BSR_LEN-1:0];
    din = {$urandom(), $urandom()};
    din[63:BSR_LEN] = '0;
    shift_dr(BSR_LEN, din, dout, en);
    e = exp_out(dr_cap(4'h1), dr_len(4'h1), din, BSR_LEN);
    vec++;
    if (dout !== e) begin err++; $display("FAIL smp_shift got %h want %h", dout, e); end
    tick(1'b1, 1'b0);
    m_bsr_upd = din[BSR_LEN-1:0];
    vec++;
    if (bsr_update !== m_bsr_upd) begin
      err++; $display("FAIL smp_upd got %h want %h", bsr_update, m_bsr_upd);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_user;
    logic [IR_LEN-1:0] cap;
    logic [63:0] din, dout, e;
    logic en;
    load_ir(4'h3, cap);
    for (int i = 0; i < 5; i++) begin
      user_cap = (i == 0) ? 8'hA5 : 8'($urandom());
      din = (i == 0) ? 64'h3C : 64'(8'($urandom()));
      shift_dr(USER_LEN, din, dout, en);
      e = exp_out(dr_cap(4'h3), dr_len(4'h3), din, USER_LEN);
      vec += 2;
      if (dout !== e) begin err++; $display("FAIL usr_shift got %h want %h", dout, e); end
      if (user_strobe !== 1'b0) begin err++; $display("FAIL usr_strb_pre got %b want 0", user_strobe); end
      tick(1'b1, 1'b0);
      vec += 2;
      if (user_update !== din[USER_LEN-1:0]) begin
        err++; $display("FAIL usr_upd got %h want %h", user_update, din[USER_LEN-1:0]);
      end
      if (user_strobe !== 1'b1) begin err++; $display("FAIL usr_strb got %b want 1", user_strobe); end
      tick(1'b0, 1'b0);
      vec++;
      if (user_strobe !== 1'b0) begin err++; $display("FAIL usr_strb_post got %b want 0", user_strobe); end
    end
  endtask

  task automatic test_pause;
    logic [63:0] din, dout, e;
    user_cap = 8'($urandom());
    din = 64'(8'($urandom()));
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    dout[0] = TDO;
    for (int k = 0; k < 4; k++) begin
      tick(k == 3, din[k]);
      if (k < 3) dout[k+1] = TDO;
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    vec += 2;
    if (tap_state !== 4'd6) begin err++; $display("FAIL pau_state got %0d want 6", tap_state); end
    if (TDO_en !== 1'b0) begin err++; $display("FAIL pau_en got %b want 0", TDO_en); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    dout[4] = TDO;
    for (int k = 4; k < 8; k++) begin
      tick(k == 7, din[k]);
      if (k < 7) dout[k+1] = TDO;
    end
    tick(1'b1, 1'b0);
    e = exp_out(dr_cap(4'h3), dr_len(4'h3), din, USER_LEN);
    vec += 2;
    if (dout !== e) begin err++; $display("FAIL pau_shift got %h want %h", dout, e); end
    if (user_update !== din[USER_LEN-1:0]) begin
      err++; $display("FAIL pau_upd got %h want %h", user_update, din[USER_LEN-1:0]);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_tlr_escape;
    logic [63:0] din, e;
    logic [USER_LEN-1:0] eu;
    user_cap = 8'($urandom());
    din = 64'(3'($urandom()));
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, din[k]);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    e = exp_out(dr_cap(4'h3), dr_len(4'h3), din, 12);
    eu = e[11:4];
    vec += 4;
    if (tap_state !== 4'd0) begin err++; $display("FAIL tlr_state got %0d want 0", tap_state); end
    if (instruction !== 4'd2) begin err++; $display("FAIL tlr_instr got %h want 2", instruction); end
    if (bsr_update !== m_bsr_upd) begin
      err++; $display("FAIL tlr_bsr got %h want %h", bsr_update, m_bsr_upd);
    end
    if (user_update !== eu) begin err++; $display("FAIL tlr_user got %h want %h", user_update, eu); end
  endtask

  task automatic test_random_walk;
    logic t;
    for (int i = 0; i < 300; i++) begin
      t = 1'($urandom());
      tick(t, 1'($urandom()));
      vec += 2;
      if (tap_state !== 4'(mstate)) begin
        err++; $display("FAIL walk_state got %0d want %0d", tap_state, mstate);
      end
      if (TDO_en !== (mstate == 4 || mstate == 11)) begin
        err++; $display("FAIL walk_en got %b st %0d", TDO_en, mstate);
      end
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    vec++;
    if (tap_state !== 4'd0) begin err++; $display("FAIL walk_tlr got %0d want 0", tap_state); end
  endtask

  task automatic test_reset_mid_shift;
    logic [IR_LEN-1:0] cap;
    logic [63:0] din, dout;
    logic en;
    tick(1'b0, 1'b0);
    load_ir(4'h3, cap);
    din = 64'(8'($urandom()) | 8'h01);
    shift_dr(USER_LEN, din, dout, en);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    load_ir(4'h0, cap);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'($urandom()));
    vec += 3;
    if (TDO_en !== 1'b1) begin err++; $display("FAIL mid_en_pre got %b want 1", TDO_en); end
    if (Mode !== 1'b1) begin err++; $display("FAIL mid_mode_pre got %b want 1", Mode); end
    if (user_update !== din[USER_LEN-1:0]) begin
      err++; $display("FAIL mid_user_pre got %h want %h", user_update, din[USER_LEN-1:0]);
    end
    #2;
    Reset = 1'b1;
    #1;
    vec += 8;
    if (tap_state !== 4'd0) begin err++; $display("FAIL mid_state got %0d want 0", tap_state); end
    if (instruction !== 4'd2) begin err++; $display("FAIL mid_instr got %h want 2", instruction); end
    if (TDO !== 1'b0) begin err++; $display("FAIL mid_tdo got %b want 0", TDO); end
    if (TDO_en !== 1'b0) begin err++; $display("FAIL mid_en got %b want 0", TDO_en); end
    if (Mode !== 1'b0) begin err++; $display("FAIL mid_mode got %b want 0", Mode); end
    if (bsr_update !== '0) begin err++; $display("FAIL mid_bsr got %h want 0", bsr_update); end
    if (user_update !== '0) begin err++; $display("FAIL mid_user got %h want 0", user_update); end
    if (user_strobe !== 1'b0) begin err++; $display("FAIL mid_strb got %b want 0", user_strobe); end
    @(negedge TCK);
    #1;
    Reset = 1'b0;
    mstate = 0;
    tick(1'b0, 1'b0);
    vec++;
    if (tap_state !== 4'd1) begin err++; $display("FAIL mid_recover got %0d want 1", tap_state); end
  endtask

  initial begin
    TMS = 1'b1;
    TDI = 1'b0;
    bsr_cap = '0;
    user_cap = '0;
    m_bsr_upd = '0;
    test_reset;
    test_idcode;
    test_bypass;
    test_unknown;
    test_extest;
    test_user;
    test_pause;
    test_tlr_escape;
    test_random_walk;
    test_reset_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
